// File: rtl/wb_pkg.sv
// +----------------------------------------------------------------------------+
// | wb_pkg : shared result-select codes, ctrl field offsets and entry type      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package wb_pkg;
  localparam logic [1:0] WB_SEL_FU   = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_PC   = 2'd2;
  localparam logic [1:0] WB_SEL_ZERO = 2'd3;

  // ctrl_i is packed {rd, we, sel[1:0]} with sel in the LSBs
  localparam int WB_CTRL_SEL_LSB = 0;
  localparam int WB_CTRL_SEL_W   = 2;
  localparam int WB_CTRL_WE_BIT  = 2;
  localparam int WB_CTRL_RD_LSB  = 3;

  localparam int WB_DATA_W = 32;
  localparam int WB_RD_W   = 5;

  typedef struct packed {
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

`default_nettype wire

// File: rtl/wb_pending_fifo.sv
// +----------------------------------------------------------------------------+
// | wb_pending_fifo : circular store of pending register-file writes           |
// | Macro WB_FWD_EN exposes the raw entries and head pointer for lookup.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_pending_fifo #(
  parameter  int DEPTH   = 2,
  parameter  int ENTRY_W = 37,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [CNT_W-1:0]         count
`ifdef WB_FWD_EN
  ,
  output logic [PTR_W-1:0]         head_ptr,
  output logic [DEPTH*ENTRY_W-1:0] entries
`endif
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

`ifdef WB_FWD_EN
  assign head_ptr = r_rd_ptr;
  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign entries[i*ENTRY_W +: ENTRY_W] = r_mem[i];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/wb_buffered_stage.sv
// +----------------------------------------------------------------------------+
// | wb_buffered_stage : write-back result select with buffered RF writes       |
// | Macro WB_FWD_EN adds combinational forwarding lookup ports.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_buffered_stage
  import wb_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int RD_W      = 5,
  parameter  int DEPTH     = 2,
  parameter  int FWD_PORTS = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DATA_W-1:0]           fu_i,
  input  logic [DATA_W-1:0]           mem_i,
  input  logic [DATA_W-1:0]           pcplus_i,
  input  logic [RD_W+2:0]             ctrl_i,
  output logic                        rf_we_o,
  output logic [RD_W-1:0]             rf_rd_o,
  output logic [DATA_W-1:0]           rf_data_o,
  input  logic                        rf_ready_i,
  output logic [CNT_W-1:0]            pending_o
`ifdef WB_FWD_EN
  ,
  input  logic [FWD_PORTS*RD_W-1:0]   fwd_addr_i,
  output logic [FWD_PORTS-1:0]        fwd_hit_o,
  output logic [FWD_PORTS*DATA_W-1:0] fwd_data_o
`endif
);

  localparam int ENTRY_W = RD_W + DATA_W;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WB_CTRL_SEL_W-1:0] w_sel;
  logic                     w_we;
  logic [RD_W-1:0]          w_rd;
  logic [DATA_W-1:0]        w_result;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic [ENTRY_W-1:0]       w_head;
  logic [CNT_W-1:0]         w_count;

  assign w_sel = ctrl_i[WB_CTRL_SEL_LSB +: WB_CTRL_SEL_W];
  assign w_we  = ctrl_i[WB_CTRL_WE_BIT];
  assign w_rd  = ctrl_i[WB_CTRL_RD_LSB +: RD_W];

  always_comb begin
    w_result = '0;
    case (w_sel)
      WB_SEL_FU:   w_result = fu_i;
      WB_SEL_MEM:  w_result = mem_i;
      WB_SEL_PC:   w_result = pcplus_i;
      WB_SEL_ZERO: w_result = '0;
      default:     w_result = '0;
    endcase
  end

  // Ready depends only on occupancy, never on the RF grant.
  assign in_ready_o = (w_count < CNT_W'(DEPTH));
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_push     = w_accept && w_we && (w_rd != '0);
  assign w_pop      = rf_we_o && rf_ready_i;

  assign pending_o  = w_count;
  assign rf_we_o    = (w_count != '0);
  assign rf_rd_o    = rf_we_o ? w_head[DATA_W +: RD_W] : '0;
  assign rf_data_o  = rf_we_o ? w_head[DATA_W-1:0]     : '0;

`ifdef WB_FWD_EN
  logic [PTR_W-1:0]         w_head_ptr;
  logic [DEPTH*ENTRY_W-1:0] w_entries;
`endif

  wb_pending_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({w_rd, w_result}),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count)
`ifdef WB_FWD_EN
    ,
    .head_ptr  (w_head_ptr),
    .entries   (w_entries)
`endif
  );

`ifdef WB_FWD_EN
  for (genvar k = 0; k < FWD_PORTS; k++) begin : g_fwd_port
    logic [RD_W-1:0]   w_addr;
    logic              w_hit;
    logic [DATA_W-1:0] w_data;

    assign w_addr = fwd_addr_i[k*RD_W +: RD_W];

    // Walk oldest to youngest so the last match wins.
    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
        int idx;
        idx = (int'(w_head_ptr) + i) % DEPTH;
        if ((i < int'(w_count)) && (w_addr != '0) &&
            (w_entries[idx*ENTRY_W + DATA_W +: RD_W] == w_addr)) begin
          w_hit  = 1'b1;
          w_data = w_entries[idx*ENTRY_W +: DATA_W];
        end
      end
    end

    assign fwd_hit_o[k]                  = w_hit;
    assign fwd_data_o[k*DATA_W +: DATA_W] = w_data;
  end
`endif

endmodule

`default_nettype wire
